// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1 UART receiver timed directly from the system clock. The
//             asynchronous RX pin is double-flopped, the start bit is
//             qualified at its centre, each data bit is sampled one bit period
//             later (LSB first), and the stop bit decides between a one-cycle
//             valid strobe and a one-cycle framing-error strobe.
//  Ports    : i_clk       system clock, rising edge
//             i_rst       synchronous reset, active low
//             i_rx        serial line, asynchronous, idles high
//             o_data      last good byte, held until the next good byte
//             o_valid     one-cycle pulse when o_data is updated
//             o_frame_err one-cycle pulse when the stop bit samples 0
//             o_busy      high whenever the receiver is not idle
//  Revision : 1.0  initial release
// ============================================================================
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1250,  // system clocks per bit, >= 4
    parameter int CNT_W        = 11     // 2**CNT_W must exceed CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    // Half a bit after the start edge lands in the middle of the start bit;
    // from there a full bit period lands in the middle of every later bit.
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             rx_meta_q;
    logic             rx_s_q;      // synchronised RX; the only copy decisions use
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= i_rx;
            rx_s_q      <= rx_meta_q;
            // Strobes default low so each can only ever last a single clock.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end

                S_START: begin
                    if (cnt_q == c_HALF_LAST) begin
                        if (!rx_s_q) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (cnt_q == c_BIT_LAST) begin
                        shift_q[idx_q] <= rx_s_q;
                        cnt_q          <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                S_BREAK: begin
                    // Wait for the line to return high so a held-low line
                    // cannot be mistaken for a stream of start bits.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver. An ideal 8N1 line driver
//             feeds directed frames from a table, hand-written corner-case
//             sequences and a random byte sweep; a monitor collects every
//             strobe and the expected byte stream is kept in a queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

    localparam int CPB   = 8;
    localparam int CW    = 4;
    localparam int LATENCY = CPB / 2 + 9 * CPB + 3;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (CW)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_rx       (rx),
        .o_data     (data),
        .o_valid    (valid),
        .o_frame_err(ferr),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge.
    // ------------------------------------------------------------------
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         wide_cnt  = 0;
    int         last_valid_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            got_q.push_back(data);
            last_valid_cyc = cyc;
        end
        if (ferr)                   ferr_cnt++;
        if (valid && ferr)          both_cnt++;
        if ((valid && prev_valid) || (ferr && prev_ferr)) wide_cnt++;
        prev_valid = valid;
        prev_ferr  = ferr;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Ideal 8N1 line driver. Called on a falling edge; returns on the
    // falling edge where the stop bit ends, so frames chain with no gap.
    // ------------------------------------------------------------------
    int fall_cyc = 0;

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] din;
        logic       stop_bit;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    logic [7:0] exp_q[$];
    int         v0, f0;
    logic [7:0] b;
    int         gap;

    initial begin
        vecs[0] = '{8'h41, 1'b1, 1, 0, 8'h41};
        vecs[1] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[3] = '{8'h7E, 1'b1, 1, 0, 8'h7E};
        vecs[4] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[6] = '{8'h80, 1'b0, 0, 1, 8'hFF};

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",  int'(data),  0);
        check("reset_valid", int'(valid), 0);
        check("reset_ferr",  int'(ferr),  0);
        check("reset_busy",  int'(busy),  0);
        rst_n = 1'b1;
        idle(10);

        // ---- latency of a single 0x41 frame ----
        v0 = valid_cnt;
        send_frame(8'h41, 1'b1);
        idle(20);
        check("lat_count", valid_cnt - v0, 1);
        check("lat_data",  int'(data), 8'h41);
        check("lat_cycles", last_valid_cyc - fall_cyc, LATENCY);

        // ---- table of directed frames ----
        for (int k = 0; k < 7; k++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[k].din, vecs[k].stop_bit);
            if (!vecs[k].stop_bit) begin
                // Line held low after a bad stop bit: must stay busy, no strobes.
                repeat (40) @(negedge clk);
                check($sformatf("vec%0d_busy_held", k), int'(busy), 1);
            end
            idle(20);
            check($sformatf("vec%0d_valid", k), valid_cnt - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k),  ferr_cnt - f0,  vecs[k].exp_ferr);
            check($sformatf("vec%0d_data", k),  int'(data),     int'(vecs[k].exp_data));
            check($sformatf("vec%0d_idle", k),  int'(busy),     0);
        end

        // ---- 2-clock glitch, then a good 0xA5 ----
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr",  ferr_cnt - f0,  0);
        check("glitch_busy",  int'(busy),     0);
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("post_glitch_valid", valid_cnt - v0, 1);
        check("post_glitch_data",  int'(data), 8'hA5);

        // ---- back-to-back 0x00 then 0xFF ----
        got_q.delete();
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b_count", valid_cnt - v0, 2);
        check("b2b_first",  (got_q.size() > 0) ? int'(got_q[0]) : -1, 8'h00);
        check("b2b_second", (got_q.size() > 1) ? int'(got_q[1]) : -1, 8'hFF);

        // ---- reset during bit 3 of 0x55, then 0x81 ----
        v0 = valid_cnt;
        f0 = ferr_cnt;
        b  = 8'h55;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_data",  int'(data),  0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ferr",  int'(ferr),  0);
        check("midrst_busy",  int'(busy),  0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        check("abort_valid", valid_cnt - v0, 0);
        check("abort_ferr",  ferr_cnt - f0,  0);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_data",  int'(data), 8'h81);

        // ---- random sweep of 256 bytes against the expected stream ----
        got_q.delete();
        exp_q.delete();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int n = 0; n < 256; n++) begin
            b   = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 3));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            if (gap != 0) idle(gap);
        end
        idle(20);
        check("rand_valid_count", valid_cnt - v0, 256);
        check("rand_ferr_count",  ferr_cnt - f0,  0);
        for (int n = 0; n < 256; n++) begin
            check($sformatf("rand_byte%0d", n),
                  (n < got_q.size()) ? int'(got_q[n]) : -1, int'(exp_q[n]));
        end

        // ---- strobe properties over the whole run ----
        check("strobes_exclusive", both_cnt, 0);
        check("strobes_one_clock", wide_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
